// File: rtl/lfo_pkg.sv
// Shared encodings and quarter-wave sine table generator for the LFO bank.
package lfo_pkg;

   typedef enum logic [1:0] {
      LFO_SINE = 2'd0,
      LFO_TRI  = 2'd1,
      LFO_SAW  = 2'd2,
      LFO_SQR  = 2'd3
   } lfo_mode_e;

   typedef enum logic [1:0] {
      CFG_KFREQ = 2'd0,
      CFG_AMP   = 2'd1,
      CFG_MODE  = 2'd2,
      CFG_PHASE = 2'd3
   } lfo_cfg_sel_e;

   // pi/2 in unsigned Q60 fixed point
   localparam logic [127:0] HALF_PI_Q60 = 128'h1921FB54442D1846;

   // round((2^(ww-1)-1) * sin(pi/2 * (k+0.5) / 2^qb)), evaluated at elaboration
   // with a Horner-form Taylor series in Q60 so rounding is exact for the table sizes used.
   function automatic int lut_entry(input int k, input int qb, input int ww);
      logic [127:0] one, x, x2, h, s;
      one = 128'd1 << 60;
      x   = (HALF_PI_Q60 * 128'(2 * k + 1)) >> (qb + 1);
      x2  = (x * x) >> 60;
      h   = one;
      for (int n = 8; n >= 1; n--) begin
         h = one - ((x2 * h) >> 60) / 128'((2 * n) * (2 * n + 1));
      end
      s = (x * h) >> 60;
      s = (s * 128'((1 << (ww - 1)) - 1) + (one >> 1)) >> 60;
      return int'(s);
   endfunction

endpackage

// File: rtl/lfo_sin_lut.sv
// Registered quarter-wave sine ROM with quadrant folding and negation.
// A second read port exists only when LFO_QUAD_EN is defined.
module lfo_sin_lut
   import lfo_pkg::*;
#(
   parameter int unsigned WW = 16,
   parameter int unsigned QB = 8
) (
   input  logic                 mclk,
   input  logic [QB+1:0]        addr_a,
   output logic signed [WW-1:0] data_a
`ifdef LFO_QUAD_EN
   ,
   input  logic [QB+1:0]        addr_b,
   output logic signed [WW-1:0] data_b
`endif
);

   logic [WW-2:0] rom [2**QB];

   for (genvar k = 0; k < 2**QB; k++) begin : g_rom
      localparam int Entry = lut_entry(k, QB, WW);
      assign rom[k] = Entry[WW-2:0];
   end

   // Address is {quadrant, index}; odd quadrants read mirrored, upper half negated.
   function automatic logic signed [WW-1:0] fold(input logic [QB+1:0] a);
      logic [QB-1:0]        idx;
      logic signed [WW-1:0] mag;
      idx = a[QB] ? ~a[QB-1:0] : a[QB-1:0];
      mag = $signed({1'b0, rom[idx]});
      return a[QB+1] ? -mag : mag;
   endfunction

   always_ff @(posedge mclk) begin
      data_a <= fold(addr_a);
`ifdef LFO_QUAD_EN
      data_b <= fold(addr_b);
`endif
   end

endmodule

// File: rtl/lfo_bank.sv
// Time-multiplexed LFO bank: one shared phase/LUT/multiply pipeline swept across all
// channels per tick. Define LFO_QUAD_EN for the quadrature (lfo_cos) path.
module lfo_bank
   import lfo_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned PW  = 20,
   parameter int unsigned FW  = 9,
   parameter int unsigned AW  = 15,
   parameter int unsigned WW  = 16,
   parameter int unsigned QB  = 8,
   localparam int unsigned OW = WW + AW,
   localparam int unsigned CW = $clog2(NCH)
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              tick,
   input  logic              cfg_we,
   input  logic [CW-1:0]     cfg_ch,
   input  logic [1:0]        cfg_sel,
   input  logic [31:0]       cfg_wdata,
   input  logic              ovr_clr,
   output logic [NCH*OW-1:0] lfo_sin,
   output logic [NCH*OW-1:0] lfo_cos,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam logic [WW-1:0] SqrPos  = {1'b0, {(WW-1){1'b1}}};
   localparam logic [WW-1:0] SqrNeg  = ~SqrPos + 1'b1;
   localparam logic [WW:0]   Quarter = {2'b01, {(WW-1){1'b0}}};
   localparam logic [CW-1:0] LastCh  = CW'(NCH - 1);

   logic [PW-1:0] phase_q [NCH];
   logic [FW-1:0] kfreq_q [NCH];
   logic [AW-1:0] amp_q   [NCH];
   logic [1:0]    mode_q  [NCH];

   logic          run_q, busy_q, done_q, ovr_q;
   logic [CW-1:0] cnt_q;

   logic          s1_valid_q, s2_valid_q;
   logic [CW-1:0] s1_ch_q, s2_ch_q;
   logic [1:0]    s1_mode_q, s2_mode_q;
   logic [AW-1:0] s1_amp_q, s2_amp_q;
   logic [WW:0]   s1_top_q;
   logic signed [WW-1:0] s2_wave_q;

   logic [OW*NCH-1:0] lfo_sin_q;
   logic [PW-1:0]     phase_acc;
   logic              end_sweep, start;
   logic              unused_wdata;

   // Top WW+1 phase bits: p[PW-1 -: WW+1]. Saw uses the upper WW, triangle the lower WW.
   function automatic logic signed [WW-1:0] wave_fn(input logic [1:0] m, input logic [WW:0] pt);
      logic [WW-1:0] u, t, w;
      u = pt[WW-1:0];
      t = pt[WW:1];
      case (m)
         LFO_TRI: w = (pt[WW] ? ~u : u) ^ {1'b1, {(WW-1){1'b0}}};
         LFO_SAW: w = {~t[WW-1], t[WW-2:0]};
         LFO_SQR: w = pt[WW] ? SqrNeg : SqrPos;
         default: w = '0;
      endcase
      return $signed(w);
   endfunction

   assign unused_wdata = ^cfg_wdata[31:PW];
   assign phase_acc    = phase_q[cnt_q] + PW'(kfreq_q[cnt_q]);
   assign end_sweep    = s2_valid_q && (s2_ch_q == LastCh);
   // A tick on the edge where busy falls starts the next sweep.
   assign start        = tick && (!busy_q || end_sweep);

   always_ff @(posedge mclk) begin
      if (reset) begin
         run_q  <= 1'b0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         done_q <= end_sweep;
         ovr_q  <= (ovr_q & ~ovr_clr) | (tick & busy_q & ~end_sweep);
         if (start) begin
            run_q  <= 1'b1;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else begin
            if (end_sweep) busy_q <= 1'b0;
            if (run_q) begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastCh) run_q <= 1'b0;
            end
         end
      end
   end

   // A phase write after the accumulate step in the same cycle overrides it.
   always_ff @(posedge mclk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            phase_q[i] <= '0;
            kfreq_q[i] <= '0;
            amp_q[i]   <= '0;
            mode_q[i]  <= '0;
         end
      end else begin
         if (run_q) phase_q[cnt_q] <= phase_acc;
         if (cfg_we) begin
            unique case (cfg_sel)
               CFG_KFREQ: kfreq_q[cfg_ch] <= cfg_wdata[FW-1:0];
               CFG_AMP:   amp_q[cfg_ch]   <= cfg_wdata[AW-1:0];
               CFG_MODE:  mode_q[cfg_ch]  <= cfg_wdata[1:0];
               CFG_PHASE: phase_q[cfg_ch] <= cfg_wdata[PW-1:0];
            endcase
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= run_q;
         s2_valid_q <= s1_valid_q;
      end
      s1_ch_q   <= cnt_q;
      s1_mode_q <= mode_q[cnt_q];
      s1_amp_q  <= amp_q[cnt_q];
      s1_top_q  <= phase_acc[PW-1 -: WW+1];
      s2_ch_q   <= s1_ch_q;
      s2_mode_q <= s1_mode_q;
      s2_amp_q  <= s1_amp_q;
      s2_wave_q <= wave_fn(s1_mode_q, s1_top_q);
   end

   logic [QB+1:0]        lut_addr_a;
   logic signed [WW-1:0] lut_data_a, sin_sel;
   logic signed [OW-1:0] sin_x, amp_x, sin_prod;

   assign lut_addr_a = s1_top_q[WW -: QB+2];

`ifdef LFO_QUAD_EN
   logic [WW:0]          top_cos;
   logic [QB+1:0]        lut_addr_b;
   logic signed [WW-1:0] lut_data_b, cos_sel, s2_wave_c_q;
   logic signed [OW-1:0] cos_x, cos_prod;
   logic [OW*NCH-1:0]    lfo_cos_q;

   assign top_cos    = s1_top_q + Quarter;
   assign lut_addr_b = top_cos[WW -: QB+2];

   always_ff @(posedge mclk) begin
      s2_wave_c_q <= wave_fn(s1_mode_q, top_cos);
   end
`endif

   lfo_sin_lut #(
      .WW (WW),
      .QB (QB)
   ) u_lut (
      .mclk   (mclk),
      .addr_a (lut_addr_a),
      .data_a (lut_data_a)
`ifdef LFO_QUAD_EN
      ,
      .addr_b (lut_addr_b),
      .data_b (lut_data_b)
`endif
   );

   assign sin_sel  = (s2_mode_q == LFO_SINE) ? lut_data_a : s2_wave_q;
   assign sin_x    = OW'(sin_sel);
   assign amp_x    = OW'(s2_amp_q);
   assign sin_prod = sin_x * amp_x;

   always_ff @(posedge mclk) begin
      if (reset) lfo_sin_q <= '0;
      else if (s2_valid_q) lfo_sin_q[s2_ch_q*OW +: OW] <= sin_prod;
   end

`ifdef LFO_QUAD_EN
   assign cos_sel  = (s2_mode_q == LFO_SINE) ? lut_data_b : s2_wave_c_q;
   assign cos_x    = OW'(cos_sel);
   assign cos_prod = cos_x * amp_x;

   always_ff @(posedge mclk) begin
      if (reset) lfo_cos_q <= '0;
      else if (s2_valid_q) lfo_cos_q[s2_ch_q*OW +: OW] <= cos_prod;
   end

   assign lfo_cos = lfo_cos_q;
`else
   assign lfo_cos = '0;
`endif

   assign lfo_sin = lfo_sin_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = ovr_q;

endmodule
